// File: rtl/boot_word_loader.sv
// ---------------------------------------------------------------------------
// boot_word_loader
//
// Receives a boot image from a UART byte stream and writes it into the
// instruction memory as 32-bit words.
//
// Stream format: LEN_HI LEN_LO (big-endian word count N), then N words of
// four bytes each, MSB first.  If the macro BOOT_CHECKSUM_EN is defined,
// one trailer byte follows.  It must equal the XOR of all payload bytes.
//
// Ports
//   clk         single clock, rising edge
//   rst_n       asynchronous active-low reset
//   boot_en     level arm; low aborts or idles the loader
//   rx_rdy      UART received-byte-valid
//   rx_data     UART received byte
//   clr_rx_rdy  byte-consumed strobe back to the UART (combinational)
//   mem_we      one-cycle memory write strobe
//   mem_addr    memory word address (ADDR_W bits, wraps)
//   mem_wdata   assembled 32-bit write data
//   busy        high in every state except IDLE and DONE
//   boot_done   image fully loaded (held in DONE)
//   boot_err    trailer checksum mismatch, sticky until IDLE
//
// Configuration macro: BOOT_CHECKSUM_EN (default build: undefined, no trailer)
// ---------------------------------------------------------------------------
module boot_word_loader #(
   parameter int ADDR_W    = 12,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              boot_en,
   input  logic              rx_rdy,
   input  logic [7:0]        rx_data,
   output logic              clr_rx_rdy,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              busy,
   output logic              boot_done,
   output logic              boot_err
);

   // state  | meaning
   // IDLE   | disarmed, waiting for boot_en
   // LEN_HI | waiting for word-count high byte
   // LEN_LO | waiting for word-count low byte
   // BYTE1  | waiting for word bits [31:24]
   // BYTE2  | waiting for word bits [23:16]
   // BYTE3  | waiting for word bits [15:8]
   // BYTE4  | waiting for word bits [7:0]
   // WRITE  | mem_we pulse, then advance address and count
   // CHECK  | trailer check (or single pass-through cycle)
   // DONE   | image loaded, hold until boot_en drops
   localparam logic [3:0] S_IDLE   = 4'd0;
   localparam logic [3:0] S_LEN_HI = 4'd1;
   localparam logic [3:0] S_LEN_LO = 4'd2;
   localparam logic [3:0] S_BYTE1  = 4'd3;
   localparam logic [3:0] S_BYTE2  = 4'd4;
   localparam logic [3:0] S_BYTE3  = 4'd5;
   localparam logic [3:0] S_BYTE4  = 4'd6;
   localparam logic [3:0] S_WRITE  = 4'd7;
   localparam logic [3:0] S_CHECK  = 4'd8;
   localparam logic [3:0] S_DONE   = 4'd9;

   localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

   logic [3:0]  state;
   logic [3:0]  state_nxt;
   logic [15:0] count;
   logic        acc_q;
   logic        rx_state;
   logic        accept;

   always_comb begin
      rx_state = 1'b0;
      case (state)
         S_LEN_HI, S_LEN_LO, S_BYTE1, S_BYTE2, S_BYTE3, S_BYTE4: rx_state = 1'b1;
`ifdef BOOT_CHECKSUM_EN
         S_CHECK: rx_state = 1'b1;
`endif
         default: rx_state = 1'b0;
      endcase
   end

   // acc_q blocks the cycle after an acceptance.  The UART's rx_rdy may
   // still read high there before it sees clr_rx_rdy.
   assign accept     = rx_state & rx_rdy & ~acc_q & boot_en;
   assign clr_rx_rdy = accept;

   // Gated by boot_en so that an abort landing on WRITE produces no strobe.
   assign mem_we    = (state == S_WRITE) & boot_en;
   assign busy      = (state != S_IDLE) && (state != S_DONE);
   assign boot_done = (state == S_DONE);

   always_comb begin
      state_nxt = state;
      if ((state != S_IDLE) && !boot_en) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE:   if (boot_en) state_nxt = S_LEN_HI;
            S_LEN_HI: if (accept)  state_nxt = S_LEN_LO;
            S_LEN_LO:
               if (accept) begin
                  if ({count[15:8], rx_data} == 16'd0) state_nxt = S_CHECK;
                  else                                 state_nxt = S_BYTE1;
               end
            S_BYTE1:  if (accept) state_nxt = S_BYTE2;
            S_BYTE2:  if (accept) state_nxt = S_BYTE3;
            S_BYTE3:  if (accept) state_nxt = S_BYTE4;
            S_BYTE4:  if (accept) state_nxt = S_WRITE;
            S_WRITE:
               if (count == 16'd1) state_nxt = S_CHECK;
               else                state_nxt = S_BYTE1;
`ifdef BOOT_CHECKSUM_EN
            S_CHECK:  if (accept) state_nxt = S_DONE;
`else
            S_CHECK:  state_nxt = S_DONE;
`endif
            S_DONE:   state_nxt = S_DONE;
            default:  state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         acc_q     <= 1'b0;
         count     <= 16'd0;
         mem_addr  <= BASE;
         mem_wdata <= 32'd0;
      end else begin
         state <= state_nxt;
         acc_q <= accept;
         case (state)
            S_IDLE:
               if (boot_en) mem_addr <= BASE;
            S_LEN_HI:
               if (accept) count[15:8] <= rx_data;
            S_LEN_LO:
               if (accept) count[7:0] <= rx_data;
            S_BYTE1:
               if (accept) mem_wdata[31:24] <= rx_data;
            S_BYTE2:
               if (accept) mem_wdata[23:16] <= rx_data;
            S_BYTE3:
               if (accept) mem_wdata[15:8] <= rx_data;
            S_BYTE4:
               if (accept) mem_wdata[7:0] <= rx_data;
            S_WRITE:
               if (boot_en) begin
                  // ADDR_W-bit add wraps naturally when N exceeds the space.
                  mem_addr <= mem_addr + 1'b1;
                  count    <= count - 16'd1;
               end
            default: ;
         endcase
      end
   end

`ifdef BOOT_CHECKSUM_EN
   logic [7:0] csum;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         csum     <= 8'd0;
         boot_err <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               boot_err <= 1'b0;
               if (boot_en) csum <= 8'd0;
            end
            S_BYTE1, S_BYTE2, S_BYTE3, S_BYTE4:
               if (accept) csum <= csum ^ rx_data;
            S_CHECK:
               if (accept) boot_err <= (rx_data != csum);
            default: ;
         endcase
      end
   end
`else
   assign boot_err = 1'b0;
`endif

endmodule

// File: tb/tb_boot_word_loader.sv
module tb_boot_word_loader;

   typedef logic [7:0] byte_q_t[$];

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        boot_en, rx_rdy;
   logic [7:0]  rx_data;
   logic        clr, mem_we, busy, done, err;
   logic [11:0] mem_addr;
   logic [31:0] mem_wdata;

   logic        boot_en_w, rx_rdy_w;
   logic [7:0]  rx_data_w;
   logic        clr_w, mem_we_w, busy_w, done_w, err_w;
   logic [1:0]  mem_addr_w;
   logic [31:0] mem_wdata_w;

   int total = 0;
   int bad   = 0;

   logic [43:0] q[$];
   logic [33:0] q_w[$];

   boot_word_loader #(.ADDR_W(12), .BASE_ADDR(0)) dut (
      .clk(clk), .rst_n(rst_n), .boot_en(boot_en), .rx_rdy(rx_rdy),
      .rx_data(rx_data), .clr_rx_rdy(clr), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy),
      .boot_done(done), .boot_err(err));

   boot_word_loader #(.ADDR_W(2), .BASE_ADDR(0)) dut_w (
      .clk(clk), .rst_n(rst_n), .boot_en(boot_en_w), .rx_rdy(rx_rdy_w),
      .rx_data(rx_data_w), .clr_rx_rdy(clr_w), .mem_we(mem_we_w),
      .mem_addr(mem_addr_w), .mem_wdata(mem_wdata_w), .busy(busy_w),
      .boot_done(done_w), .boot_err(err_w));

   // Scoreboard: every write strobe pops one expected {addr,data}.
   logic prev_we = 1'b0, prev_we_w = 1'b0;
   always @(negedge clk) begin
      logic [43:0] e;
      logic [33:0] e_w;
      #2;
      if (mem_we === 1'b1) begin
         total++;
         if (prev_we !== 1'b0) begin
            bad++;
            $display("FAIL we_width: mem_we high for 2+ cycles, required 1 cycle");
         end
         total++;
         if (q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_write: addr=%h data=%h, required no write", mem_addr, mem_wdata);
         end else begin
            e = q.pop_front();
            if ({mem_addr, mem_wdata} !== e)
               begin bad++; $display("FAIL write: got %h@%h, required %h@%h", mem_wdata, mem_addr, e[31:0], e[43:32]); end
         end
      end
      prev_we = mem_we;
      if (mem_we_w === 1'b1) begin
         total++;
         if (prev_we_w !== 1'b0) begin
            bad++;
            $display("FAIL we_width_w: mem_we high for 2+ cycles, required 1 cycle");
         end
         total++;
         if (q_w.size() == 0) begin
            bad++;
            $display("FAIL unexpected_write_w: addr=%h data=%h, required no write", mem_addr_w, mem_wdata_w);
         end else begin
            e_w = q_w.pop_front();
            if ({mem_addr_w, mem_wdata_w} !== e_w)
               begin bad++; $display("FAIL write_w: got %h@%h, required %h@%h", mem_wdata_w, mem_addr_w, e_w[31:0], e_w[33:32]); end
         end
      end
      prev_we_w = mem_we_w;
   end

   function automatic logic [7:0] xor_payload(input byte_q_t bs);
      logic [7:0] x = 8'h00;
      for (int i = 2; i < bs.size(); i++) x ^= bs[i];
      return x;
   endfunction

   task automatic send_byte(input bit w, input logic [7:0] b, input int hold);
      int n, seen;
      @(negedge clk);
      if (w) begin rx_rdy_w = 1'b1; rx_data_w = b; end
      else   begin rx_rdy   = 1'b1; rx_data   = b; end
      #1;
      n = 0;
      while (((w ? clr_w : clr) !== 1'b1) && n < 40) begin @(negedge clk); #1; n++; end
      total++;
      seen = 0;
      if ((w ? clr_w : clr) !== 1'b1) begin
         bad++;
         $display("FAIL byte_accept: byte %h not consumed within 40 cycles, required consumption", b);
      end else seen = 1;
      for (int i = 1; i < hold; i++) begin
         @(negedge clk); #1;
         if ((w ? clr_w : clr) === 1'b1) seen++;
      end
      if (hold > 1) begin
         total++;
         if (seen != 1) begin
            bad++;
            $display("FAIL single_accept: byte %h consumed %0d times, required 1", b, seen);
         end
      end
      @(negedge clk);
      if (w) rx_rdy_w = 1'b0; else rx_rdy = 1'b0;
   endtask

   task automatic send_seq(input bit w, input byte_q_t bs, input int hold);
      for (int i = 0; i < bs.size(); i++) send_byte(w, bs[i], hold);
`ifdef BOOT_CHECKSUM_EN
      send_byte(w, xor_payload(bs), hold);
`endif
   endtask

   task automatic wait_done(input bit w);
      int n = 0;
      @(negedge clk); #1;
      while (((w ? done_w : done) !== 1'b1) && n < 60) begin @(negedge clk); #1; n++; end
      total++;
      if ((w ? done_w : done) !== 1'b1) begin
         bad++;
         $display("FAIL boot_done_timeout: boot_done=%b after 60 cycles, required 1", w ? done_w : done);
      end
   endtask

   task automatic arm(input bit w);
      @(negedge clk);
      if (w) boot_en_w = 1'b1; else boot_en = 1'b1;
   endtask

   task automatic disarm(input bit w);
      @(negedge clk);
      if (w) boot_en_w = 1'b0; else boot_en = 1'b0;
      @(negedge clk); #1;
      total++;
      if ((w ? {busy_w, done_w, err_w} : {busy, done, err}) !== 3'b000) begin
         bad++;
         $display("FAIL disarm: busy/done/err=%b, required 000", w ? {busy_w, done_w, err_w} : {busy, done, err});
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; boot_en = 1'b0; rx_rdy = 1'b0; rx_data = 8'h00;
      boot_en_w = 1'b0; rx_rdy_w = 1'b0; rx_data_w = 8'h00;
      #1;
      total++;
      if ({mem_we, clr, busy, done, err} !== 5'b00000) begin
         bad++; $display("FAIL reset_flags: we/clr/busy/done/err=%b, required 00000", {mem_we, clr, busy, done, err});
      end
      total++;
      if (mem_addr !== 12'h000) begin bad++; $display("FAIL reset_addr: %h, required 000", mem_addr); end
      total++;
      if (mem_wdata !== 32'h0) begin bad++; $display("FAIL reset_wdata: %h, required 00000000", mem_wdata); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk); #1;
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy: %b, required 0", busy); end
   endtask

   task automatic test_single();
      arm(0);
      q.push_back({12'h000, 32'hDEADBEEF});
      send_seq(0, '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF}, 1);
      wait_done(0);
      total++;
      if (err !== 1'b0) begin bad++; $display("FAIL single_err: %b, required 0", err); end
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL single_busy: %b, required 0", busy); end
      total++;
      if (q.size() != 0) begin bad++; $display("FAIL single_writes: %0d pending, required 0", q.size()); end
      total++;
      if (mem_addr !== 12'h001) begin bad++; $display("FAIL single_addr_after: %h, required 001", mem_addr); end
      disarm(0);
   endtask

   task automatic test_two_words();
      arm(0);
      q.push_back({12'h000, 32'h11223344});
      q.push_back({12'h001, 32'h55667788});
      send_seq(0, '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88}, 1);
      wait_done(0);
      total++;
      if (q.size() != 0) begin bad++; $display("FAIL two_words_writes: %0d pending, required 0", q.size()); end
      disarm(0);
   endtask

   task automatic test_zero_len();
      arm(0);
      send_seq(0, '{8'h00, 8'h00}, 1);
      wait_done(0);
      total++;
      if (err !== 1'b0) begin bad++; $display("FAIL zero_err: %b, required 0", err); end
      disarm(0);
   endtask

   task automatic test_abort();
      arm(0);
      send_seq(0, '{8'h00, 8'h01, 8'h11, 8'h22}, 1);
      @(negedge clk);
      boot_en = 1'b0;
      @(negedge clk); #1;
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy: %b, required 0", busy); end
      repeat (4) @(negedge clk);
      arm(0);
      q.push_back({12'h000, 32'hCAFEBABE});
      send_seq(0, '{8'h00, 8'h01, 8'hCA, 8'hFE, 8'hBA, 8'hBE}, 1);
      wait_done(0);
      total++;
      if (q.size() != 0) begin bad++; $display("FAIL rearm_writes: %0d pending, required 0", q.size()); end
      disarm(0);
   endtask

   task automatic test_reset_mid();
      arm(0);
      send_seq(0, '{8'h00, 8'h02, 8'hAA, 8'hBB, 8'hCC}, 1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      total++;
      if ({busy, mem_we, mem_addr, mem_wdata} !== 46'd0) begin
         bad++; $display("FAIL mid_reset: busy=%b we=%b addr=%h data=%h, required all 0", busy, mem_we, mem_addr, mem_wdata);
      end
      @(negedge clk);
      rst_n = 1'b1;
      q.push_back({12'h000, 32'h01020304});
      send_seq(0, '{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04}, 1);
      wait_done(0);
      total++;
      if (q.size() != 0) begin bad++; $display("FAIL post_reset_writes: %0d pending, required 0", q.size()); end
      disarm(0);
   endtask

   task automatic test_wrap();
      byte_q_t bs;
      logic [31:0] word;
      bs = '{8'h00, 8'h05};
      for (int i = 0; i < 5; i++) begin
         word = {8'(16 * i + 1), 8'(16 * i + 2), 8'(16 * i + 3), 8'(16 * i + 4)};
         q_w.push_back({2'(i), word});
         for (int k = 3; k >= 0; k--) bs.push_back(word[8 * k +: 8]);
      end
      arm(1);
      send_seq(1, bs, 2);
      wait_done(1);
      total++;
      if (q_w.size() != 0) begin bad++; $display("FAIL wrap_writes: %0d pending, required 0", q_w.size()); end
      total++;
      if (err_w !== 1'b0) begin bad++; $display("FAIL wrap_err: %b, required 0", err_w); end
      disarm(1);
   endtask

`ifdef BOOT_CHECKSUM_EN
   task automatic test_bad_trailer();
      arm(0);
      q.push_back({12'h000, 32'hDEADBEEF});
      send_byte(0, 8'h00, 1);
      send_byte(0, 8'h01, 1);
      send_byte(0, 8'hDE, 1);
      send_byte(0, 8'hAD, 1);
      send_byte(0, 8'hBE, 1);
      send_byte(0, 8'hEF, 1);
      send_byte(0, 8'h00, 1);
      wait_done(0);
      total++;
      if (err !== 1'b1) begin bad++; $display("FAIL bad_trailer_err: %b, required 1", err); end
      disarm(0);
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_two_words();
      test_zero_len();
      test_abort();
      test_reset_mid();
      test_wrap();
`ifdef BOOT_CHECKSUM_EN
      test_bad_trailer();
`endif
      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/boot_word_loader.md
BOOT_WORD_LOADER -- requirements
Module: boot_word_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, meaning the width of the memory word address.
REQ-002 SHALL have parameter BASE_ADDR, default 0, meaning the address of the first word written.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port boot_en, input, 1 bit: level-sensitive arm; low aborts or idles the loader.
REQ-006 SHALL have port rx_rdy, input, 1 bit: UART received-byte-valid.
REQ-007 SHALL have port rx_data, input, 8 bits: UART received byte, valid while rx_rdy=1.
REQ-008 SHALL have port clr_rx_rdy, output, 1 bit: byte-consumed strobe to the UART.
REQ-009 SHALL have port mem_we, output, 1 bit: one-cycle instruction-memory write strobe.
REQ-010 SHALL have port mem_addr, output, ADDR_W bits: write address.
REQ-011 SHALL have port mem_wdata, output, 32 bits: write data.
REQ-012 SHALL have port busy, output, 1 bit: high in every state except IDLE and DONE.
REQ-013 SHALL have port boot_done, output, 1 bit: image fully loaded.
REQ-014 SHALL have port boot_err, output, 1 bit: checksum mismatch, sticky until IDLE.

Function
REQ-015 SHALL use states IDLE, LEN_HI, LEN_LO, BYTE1, BYTE2, BYTE3, BYTE4, WRITE, CHECK, DONE.
REQ-016 SHALL go IDLE->LEN_HI on boot_en=1, loading mem_addr with BASE_ADDR and the checksum with 0.
REQ-017 SHALL accept a byte in any receiving state in the cycle rx_rdy=1, and assert clr_rx_rdy combinationally in that same cycle only.
REQ-018 SHALL NOT accept a byte in the cycle after an acceptance, so a stale rx_rdy is not double-counted.
REQ-019 SHALL interpret LEN_HI/LEN_LO as a 16-bit big-endian word count N.
REQ-020 SHALL go LEN_LO->CHECK when N=0; otherwise LEN_LO->BYTE1.
REQ-021 SHALL assemble BYTE1..BYTE4 big-endian: BYTE1 gives mem_wdata[31:24] and BYTE4 gives [7:0].
REQ-022 SHALL, in WRITE, pulse mem_we for exactly one cycle with the stable assembled word and current mem_addr, then increment mem_addr and decrement the remaining count.
REQ-023 SHALL make the WRITE latency exactly one cycle after BYTE4 acceptance.
REQ-024 SHALL go WRITE->BYTE1 while words remain, and WRITE->CHECK after the Nth write.
REQ-025 SHALL let mem_addr wrap modulo 2^ADDR_W with no error when N exceeds the address space.
REQ-026 SHALL go CHECK->DONE as defined under Configuration; DONE holds boot_done=1 until boot_en=0, then goes to IDLE.
REQ-027 SHALL, when boot_en falls in any state other than IDLE, go to IDLE next cycle with no further mem_we, and the partial word discarded.
REQ-028 SHALL hold mem_addr and mem_wdata stable while mem_we=0, except on state entry/assembly updates.

Reset
REQ-029 SHALL, on rst_n=0, immediately enter IDLE with mem_we=0, clr_rx_rdy=0, busy=0, boot_done=0, boot_err=0, mem_addr=BASE_ADDR, mem_wdata=0, count=0 and checksum=0.
REQ-030 SHALL NOT issue a write on reset assertion mid-image, and SHALL require a new LEN header after release.

Configuration
REQ-031 SHALL support macro BOOT_CHECKSUM_EN.
REQ-032 SHALL, when BOOT_CHECKSUM_EN is defined, XOR every payload byte (not length bytes) into an 8-bit checksum; in CHECK, accept one trailer byte and set boot_err=1 if it differs, then go to DONE.
REQ-033 SHALL, when BOOT_CHECKSUM_EN is undefined, pass through CHECK to DONE in one cycle without consuming a byte, with boot_err tied to 0.

Verification
REQ-034 SHALL cover: boot_en=1, bytes 00 01 DE AD BE EF -> one mem_we, mem_addr=0x000, mem_wdata=0xDEADBEEF, then boot_done=1 (plus trailer 0x22 with BOOT_CHECKSUM_EN, boot_err=0).
REQ-035 SHALL cover: N=2, payload 11 22 33 44 55 66 77 88 -> writes 0x11223344@0x000 and 0x55667788@0x001, with each mem_we exactly one cycle.
REQ-036 SHALL cover: bytes 00 00 -> no mem_we and boot_done=1 (BOOT_CHECKSUM_EN: trailer 0x00 consumed first).
REQ-037 SHALL cover: boot_en dropped after BYTE2 of the first word -> no mem_we, IDLE, busy=0; re-arm with 00 01 CA FE BA BE -> 0xCAFEBABE@0x000.
REQ-038 SHALL cover: ADDR_W=2, N=5 -> fifth write at mem_addr=0x0 (wrap), and rx_rdy held high 2 cycles per byte -> each byte accepted once.
REQ-039 SHALL cover, with BOOT_CHECKSUM_EN, a wrong trailer 0x00 after DEADBEEF -> boot_err=1 and boot_done=1, with boot_err cleared after boot_en=0.
